game_state_ctrl: RTL

Sequential hit-resolution and win/lose controller that sits directly downstream of the sprite generators and upstream of the VGA pixel mux. Each cycle it checks whether a live alien's hit region and any missile region cover the current pixel, accumulates hits over the frame, and commits them at start-of-frame. From the committed state it maintains the per-alien alive mask, one-cycle missile-retire pulses, a kill counter and a PLAY/WIN/LOSE state machine. The pixel mux consumes `alien_alive`, `winner` and `loser` instead of computing strikes combinationally.

---
 rtl/game_state_if.sv | 34 +++
 rtl/game_state_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/game_state_if.sv
// Bundle between the sprite/timing side and the game state controller.
// master: sprite + timing side (drives pixel/hit inputs); slave: controller.
interface game_state_if #(
  parameter int N_ALIENS   = 15,
  parameter int N_MISSILES = 8
) ();
  logic [11:0]           pixel_row;
  logic [11:0]           pixel_column;
  logic [N_ALIENS-1:0]   alien_active;
  logic [N_MISSILES-1:0] missile_active;
  logic                  landed;
  logic                  restart;
  logic [N_ALIENS-1:0]   alien_alive;
  logic                  alien_visible;
  logic [N_MISSILES-1:0] missile_kill;
  logic [3:0]            kill_count;
  logic [1:0]            game_state;
  logic                  winner;
  logic                  loser;

  modport master (
    output pixel_row, pixel_column, alien_active,
    output missile_active, landed, restart,
    input  alien_alive, alien_visible, missile_kill,
    input  kill_count, game_state, winner, loser
  );

  modport slave (
    input  pixel_row, pixel_column, alien_active,
    input  missile_active, landed, restart,
    output alien_alive, alien_visible, missile_kill,
    output kill_count, game_state, winner, loser
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Hit resolution + PLAY/WIN/LOSE controller, commits frame hits at sof.
// Ports: vga_clk_i, vga_rst_i (async, active-high), gs (slave bundle).
module game_state_ctrl #(
  parameter int N_ALIENS   = 15,
  parameter int N_MISSILES = 8
) (
  input logic       vga_clk_i,
  input logic       vga_rst_i,
  game_state_if.slave gs
);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    WIN  = 2'b01,
    LOSE = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [N_ALIENS-1:0]   alive_q, alive_d;
  logic [N_ALIENS-1:0]   pk_q, pk_d;
  logic [N_MISSILES-1:0] pm_q, pm_d;
  logic                  pl_q, pl_d;
  logic [N_MISSILES-1:0] mk_q, mk_d;
  logic [3:0]            kill_q, kill_d;
  logic                  win_q, lose_q;

  logic                  sof;
  logic [N_ALIENS-1:0]   live_hit;
  logic [N_ALIENS-1:0]   hit_now;
  logic [N_MISSILES-1:0] mhit_now;
  logic [N_ALIENS-1:0]   new_alive;
  logic [7:0]            kill_sum;

  function automatic logic [7:0] popcnt(input logic [N_ALIENS-1:0] v);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < N_ALIENS; i++)
      s = s + 8'(v[i]);
    return s;
  endfunction

  assign sof = (gs.pixel_row == 12'd0) &&
               (gs.pixel_column == 12'd0);
  assign live_hit = gs.alien_active & alive_q;
  assign hit_now  = live_hit & {N_ALIENS{|gs.missile_active}};
  assign mhit_now = gs.missile_active & {N_MISSILES{|live_hit}};

  assign new_alive = alive_q & ~pk_q;
  assign kill_sum  = {4'd0, kill_q} + popcnt(pk_q & alive_q);

  always_comb begin
    state_d = state_q;
    alive_d = alive_q;
    kill_d  = kill_q;
    mk_d    = '0;
    pk_d    = pk_q;
    pm_d    = pm_q;
    pl_d    = pl_q;
    case (state_q)
      PLAY: begin
        if (sof) begin
          // (0,0) opens the new frame: reload, do not OR
          pk_d    = hit_now;
          pm_d    = mhit_now;
          pl_d    = gs.landed;
          alive_d = new_alive;
          mk_d    = pm_q;
          kill_d  = (kill_sum > 8'd15) ? 4'hF : kill_sum[3:0];
          if (new_alive == '0)
            state_d = WIN;
          else if (pl_q)
            state_d = LOSE;
        end else begin
          pk_d = pk_q | hit_now;
          pm_d = pm_q | mhit_now;
          pl_d = pl_q | gs.landed;
        end
      end
      default: begin
        if (sof && gs.restart) begin
          state_d = PLAY;
          alive_d = '1;
          kill_d  = '0;
          pk_d    = '0;
          pm_d    = '0;
          pl_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge vga_clk_i or posedge vga_rst_i) begin
    if (vga_rst_i) begin
      state_q <= PLAY;
      alive_q <= '1;
      kill_q  <= '0;
      mk_q    <= '0;
      pk_q    <= '0;
      pm_q    <= '0;
      pl_q    <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      kill_q  <= kill_d;
      mk_q    <= mk_d;
      pk_q    <= pk_d;
      pm_q    <= pm_d;
      pl_q    <= pl_d;
      win_q   <= (state_d == WIN);
      lose_q  <= (state_d == LOSE);
    end
  end

  assign gs.alien_alive   = alive_q;
  assign gs.alien_visible = |live_hit;
  assign gs.missile_kill  = mk_q;
  assign gs.kill_count    = kill_q;
  assign gs.game_state    = state_q;
  assign gs.winner        = win_q;
  assign gs.loser         = lose_q;

endmodule
